// File: rtl/fetch_unit.sv
// Instruction fetch front end. It keeps at most one memory request outstanding and
// feeds a 2-entry {pc, instr} buffer toward decode. A redirect flushes the buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        err_misaligned,
  output logic        err_pc_wrap
);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q;
  logic [1:0]  count_q, count_d, count_pop;
  logic        head_q;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_instr_q [2];
  logic        mis_q;
  logic        wrap_q, wrap_d;
  logic        pop, push;
  logic        tail;
  logic [31:0] target, pc_inc;

  assign o_valid        = (count_q != 2'd0);
  assign o_instr        = o_valid ? buf_instr_q[head_q] : 32'h0;
  assign o_pc           = o_valid ? buf_pc_q[head_q] : 32'h0;
  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign err_misaligned = mis_q;
  assign err_pc_wrap    = wrap_q;

  assign pop    = o_valid && i_ready;
  assign target = {redirect_pc[31:2], 2'b00};
  assign pc_inc = fetch_pc_q + 32'd4;
  assign tail   = head_q ^ count_q[0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    wrap_d     = wrap_q;
    push       = 1'b0;
    count_pop  = count_q - {1'b0, pop};
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          fetch_pc_d = target;
          addr_d     = target;
          state_d    = StWait;
        end else if (count_pop != 2'd2) begin
          addr_d  = fetch_pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          fetch_pc_d = target;
          if (imem_ack) begin
            addr_d = target;
          end else begin
            // Outstanding response still owed by memory; swallow it later.
            state_d = StDrop;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_inc;
          if (fetch_pc_q == 32'hFFFF_FFFC) wrap_d = 1'b1;
          if (count_pop == 2'd0) begin
            addr_d = pc_inc;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        if (redirect) fetch_pc_d = target;
        if (imem_ack) begin
          addr_d  = redirect ? target : fetch_pc_q;
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
    count_d = redirect ? 2'd0 : count_pop + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      req_q          <= 1'b0;
      addr_q         <= RESET_PC;
      fetch_pc_q     <= RESET_PC;
      count_q        <= 2'd0;
      head_q         <= 1'b0;
      buf_pc_q[0]    <= 32'h0;
      buf_pc_q[1]    <= 32'h0;
      buf_instr_q[0] <= 32'h0;
      buf_instr_q[1] <= 32'h0;
      mis_q          <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= (state_d != StIdle);
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      mis_q      <= redirect && (redirect_pc[1:0] != 2'b00);
      if (pop && !redirect) head_q <= ~head_q;
      if (push) begin
        buf_pc_q[tail]    <= fetch_pc_q;
        buf_instr_q[tail] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model. A second instance covers PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_ack, o_valid, i_ready, redirect, err_misaligned, err_pc_wrap;
  logic [31:0] imem_addr, imem_rdata, o_instr, o_pc, redirect_pc;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
    .i_ready(i_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .err_misaligned(err_misaligned), .err_pc_wrap(err_pc_wrap)
  );

  logic        rst2, req2, ack2, valid2, ready2, redir2, mis2, wrap2;
  logic [31:0] addr2, rdata2, instr2, pc2, rpc2;

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .o_valid(valid2), .o_instr(instr2), .o_pc(pc2),
    .i_ready(ready2), .redirect(redir2), .redirect_pc(rpc2),
    .err_misaligned(mis2), .err_pc_wrap(wrap2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delivered entries as a queue, plus the outstanding-request view.
  logic [63:0] m_q[$];
  logic [31:0] m_fpc, m_addr;
  bit          m_pend, m_stale, m_mis, m_wrap, m_rst;
  bit          chk_en = 1'b0;

  task automatic model_update();
    if (rst) begin
      m_q.delete();
      m_fpc = 32'h0; m_addr = 32'h0;
      m_pend = 0; m_stale = 0; m_mis = 0; m_wrap = 0; m_rst = 1; chk_en = 1;
      return;
    end
    m_rst = 0;
    if (redirect) begin
      m_mis = (redirect_pc[1:0] != 2'b00);
      m_q.delete();
      m_fpc = redirect_pc & 32'hFFFF_FFFC;
      if (m_pend && !imem_ack) begin
        m_stale = 1;
      end else begin
        m_pend = 1; m_stale = 0; m_addr = m_fpc;
      end
    end else begin
      m_mis = 0;
      if (m_q.size() > 0 && i_ready) void'(m_q.pop_front());
      if (m_pend && m_stale) begin
        if (imem_ack) begin m_stale = 0; m_addr = m_fpc; end
      end else if (m_pend) begin
        if (imem_ack) begin
          m_q.push_back({m_fpc, imem_rdata});
          if (m_fpc == 32'hFFFF_FFFC) m_wrap = 1;
          m_fpc = m_fpc + 32'd4;
          if (m_q.size() < 2) m_addr = m_fpc;
          else m_pend = 0;
        end
      end else if (m_q.size() < 2) begin
        m_pend = 1; m_addr = m_fpc;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (chk_en) begin
      chk("req", imem_req, m_pend);
      if (m_pend || m_rst) chk("addr", imem_addr, m_addr);
      chk("valid", o_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        e = m_q[0];
        chk("o_pc", o_pc, e[63:32]);
        chk("o_instr", o_instr, e[31:0]);
      end else if (m_rst) begin
        chk("o_pc_rst", o_pc, 32'h0);
        chk("o_instr_rst", o_instr, 32'h0);
      end
      chk("err_mis", err_misaligned, m_mis);
      chk("err_wrap", err_pc_wrap, m_wrap);
    end
  end

  // Memory responder with configurable latency.
  int   lat, cnt;
  bit   mem_en, rand_lat, spurious;
  logic req_prev;

  task automatic mem_drive();
    imem_rdata = $urandom;
    if (!mem_en) return;
    if (!imem_req) begin
      cnt = 0;
      imem_ack = spurious && ($urandom_range(0, 3) == 0);
    end else begin
      if (req_prev && imem_ack) begin
        cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end
      if (cnt >= lat) imem_ack = 1'b1;
      else begin imem_ack = 1'b0; cnt++; end
    end
  endtask

  task automatic step();
    req_prev = imem_req;
    @(posedge clk);
    model_update();
    #1;
    mem_drive();
  endtask

  bit done2 = 1'b0;

  initial begin
    logic [31:0] aq[3];
    logic [31:0] pq[3];
    int n, na;
    rst2 = 1; ack2 = 1; ready2 = 1; redir2 = 0; rpc2 = 32'h0; rdata2 = 32'h1234_5678;
    @(posedge clk); @(posedge clk); #1;
    chk("w_rst_addr", addr2, 32'hFFFF_FFF8);
    chk("w_rst_wrap", wrap2, 0);
    rst2 = 0; n = 0; na = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (req2 && na < 3) begin aq[na] = addr2; na++; end
      if (valid2 && n < 3) begin pq[n] = pc2; n++; end
    end
    chk("w_addr0", aq[0], 32'hFFFF_FFF8);
    chk("w_addr1", aq[1], 32'hFFFF_FFFC);
    chk("w_addr2", aq[2], 32'h0000_0000);
    chk("w_pc0", pq[0], 32'hFFFF_FFF8);
    chk("w_pc1", pq[1], 32'hFFFF_FFFC);
    chk("w_pc2", pq[2], 32'h0000_0000);
    chk("w_wrap_set", wrap2, 1);
    repeat (5) @(posedge clk);
    #1 chk("w_wrap_sticky", wrap2, 1);
    rst2 = 1;
    @(posedge clk); #1;
    chk("w_wrap_clr", wrap2, 0);
    done2 = 1'b1;
  end

  initial begin
    logic [31:0] pcs[3];
    int  npop;
    bit  found, got;
    rst = 1; imem_ack = 0; imem_rdata = 0; i_ready = 1; redirect = 0; redirect_pc = 0;
    mem_en = 1; rand_lat = 0; spurious = 0; lat = 0; cnt = 0; req_prev = 0;

    // Streaming from reset with single-cycle memory
    step(); step();
    chk("a_rst_req", imem_req, 0);
    chk("a_rst_addr", imem_addr, 32'h0);
    chk("a_rst_valid", o_valid, 0);
    rst = 0; npop = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_valid && i_ready) begin
        if (npop < 3) pcs[npop] = o_pc;
        npop++;
      end
    end
    chk("a_pc0", pcs[0], 32'h0);
    chk("a_pc1", pcs[1], 32'h4);
    chk("a_pc2", pcs[2], 32'h8);
    chk("a_no_gaps", npop, 7);

    // Back-pressure fills the buffer and stops fetching
    rst = 1; i_ready = 0;
    step(); step();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_valid) chk("b_hold_pc", o_pc, 32'h0);
    end
    chk("b_full_valid", o_valid, 1);
    chk("b_full_req", imem_req, 0);
    i_ready = 1;
    step();
    chk("b_resume_req", imem_req, 1);
    chk("b_resume_addr", imem_addr, 32'h8);

    // Redirect while waiting on a slow response
    rst = 1; lat = 3;
    step(); step();
    rst = 0;
    step();
    chk("c_req", imem_req, 1);
    redirect = 1; redirect_pc = 32'h100;
    step();
    redirect = 0;
    chk("c_drop_req", imem_req, 1);
    chk("c_drop_addr", imem_addr, 32'h0);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_valid) begin chk("c_first_pc", o_pc, 32'h100); got = 1; break; end
    end
    if (!got) chk("c_timeout", 0, 1);

    // Misaligned redirect target
    lat = 1;
    redirect = 1; redirect_pc = 32'h202;
    step();
    redirect = 0;
    chk("d_mis_pulse", err_misaligned, 1);
    found = imem_req && (imem_addr == 32'h200);
    step();
    chk("d_mis_clear", err_misaligned, 0);
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == 32'h200) found = 1;
      else step();
    end
    chk("d_refetch_200", found, 1);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_valid) begin chk("d_first_pc", o_pc, 32'h200); got = 1; break; end
    end
    if (!got) chk("d_timeout", 0, 1);

    // Reset mid-request, then a late response arrives
    rst = 1; lat = 3;
    step(); step();
    rst = 0;
    step(); step();
    rst = 1;
    step();
    chk("e_rst_req", imem_req, 0);
    chk("e_rst_addr", imem_addr, 32'h0);
    chk("e_rst_valid", o_valid, 0);
    mem_en = 0; rst = 0; imem_ack = 1;
    step();
    imem_ack = 0; cnt = 0;
    chk("e_refetch_req", imem_req, 1);
    chk("e_refetch_addr", imem_addr, 32'h0);
    chk("e_no_stale", o_valid, 0);
    mem_en = 1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_valid) begin chk("e_first_pc", o_pc, 32'h0); got = 1; break; end
    end
    if (!got) chk("e_timeout", 0, 1);

    // Random traffic against the model
    rand_lat = 1; spurious = 1;
    for (int i = 0; i < 4000; i++) begin
      i_ready  = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0: redirect_pc = $urandom;
        1: redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: redirect_pc = 32'($urandom_range(0, 255));
      endcase
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; redirect = 0;

    for (int i = 0; i < 100 && !done2; i++) @(posedge clk);
    if (!done2) chk("wrap_bench_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory; registered.
REQ-005 SHALL have port imem_addr  output  32  fetch address; registered.
REQ-006 SHALL have port imem_ack  input  1  instruction memory response strobe.
REQ-007 SHALL have port imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-008 SHALL have port o_valid  output  1  head buffer entry valid toward decode.
REQ-009 SHALL have port o_instr  output  32  head entry instruction.
REQ-010 SHALL have port o_pc  output  32  head entry PC.
REQ-011 SHALL have port i_ready  input  1  decode accepts head entry.
REQ-012 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-013 SHALL have port redirect_pc  input  32  redirect target.
REQ-014 SHALL have port err_misaligned  output  1  one-cycle pulse for redirect_pc[1:0]!=0.
REQ-015 SHALL have port err_pc_wrap  output  1  sticky flag for fetch PC increment carry-out.

Function
REQ-016 SHALL hold a fetch_pc register and a 2-entry FIFO of {pc, instr}; count 0..2.
REQ-017 SHALL implement states IDLE (imem_req=0), WAIT (imem_req=1, one outstanding), DROP (imem_req=1, response to be discarded).
REQ-018 SHALL keep imem_req high and imem_addr stable in WAIT/DROP until the cycle imem_ack=1; at most one outstanding request.
REQ-019 SHALL, in IDLE with no redirect, move to WAIT next cycle with imem_addr=fetch_pc when count_next<2 (count_next includes this cycle's pop).
REQ-020 SHALL, on imem_ack in WAIT without redirect, push {fetch_pc, imem_rdata}, set fetch_pc=fetch_pc+4, and go to WAIT with imem_addr=fetch_pc+4 when count_next<2 (back-to-back, no bubble), else IDLE.
REQ-021 SHALL treat o_valid&&i_ready as pop; push and pop in the same cycle SHALL leave count unchanged; FIFO SHALL never overflow or underflow.
REQ-022 SHALL keep o_valid, o_instr, o_pc stable while o_valid=1 and i_ready=0.
REQ-023 SHALL, on redirect (priority over push and pop): count<=0 (o_valid=0 next cycle), fetch_pc<={redirect_pc[31:2],2'b00}.
REQ-024 SHALL, on redirect in IDLE or in WAIT with imem_ack=1 same cycle, discard any ack data and go to WAIT at the new fetch_pc next cycle.
REQ-025 SHALL, on redirect in WAIT with imem_ack=0, go to DROP keeping the old imem_addr; on imem_ack in DROP, discard data and go to WAIT at fetch_pc.
REQ-026 SHALL, on a further redirect in DROP, update fetch_pc only and remain in DROP.
REQ-027 SHALL pulse err_misaligned for exactly the redirect cycle+1 when redirect=1 and redirect_pc[1:0]!=0.
REQ-028 SHALL wrap fetch_pc modulo 2^32 (0xFFFF_FFFC+4=0) and set err_pc_wrap on that increment.
REQ-029 SHALL ignore imem_ack while in IDLE.

Reset
REQ-030 SHALL, while rst=1 at a clock edge: state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, count=0, o_valid=0, o_instr=0, o_pc=0, err_misaligned=0, err_pc_wrap=0.
REQ-031 SHALL abandon any outstanding request on reset; rst overrides redirect, ack, pop.
REQ-032 SHALL assert first imem_req with imem_addr=RESET_PC in the cycle after the first edge with rst=0.

Verification
REQ-033 Reset release, memory acks 1 cycle after req, i_ready=1 -> o_pc sequence 0x0,0x4,0x8 with o_instr matching imem_rdata, no gaps after fill.
REQ-034 i_ready=0 for 10 cycles -> count reaches 2, imem_req=0, o_pc=0x0 held stable; i_ready=1 -> fetch resumes at 0x8.
REQ-035 Redirect to 0x100 while WAIT with ack delayed 3 cycles -> DROP, stale data discarded, next o_valid entry o_pc=0x100.
REQ-036 Redirect to 0x202 -> err_misaligned pulses one cycle, next fetch imem_addr=0x200.
REQ-037 RESET_PC=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; err_pc_wrap sets and stays 1 until rst.
REQ-038 rst asserted mid-WAIT with late ack -> outputs at reset values, late ack ignored, refetch from RESET_PC.
